out_arbiter: RTL and testbench

OUT_ARBITER -- requirements
Module: out_arbiter

---
 rtl/out_arbiter_pkg.sv | 20 ++
 rtl/rr_pick.sv | 38 +++
 rtl/out_arbiter.sv | 121 ++++++++++++
 tb/tb_out_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_arbiter_pkg.sv
// Shared definitions for the output-register arbiter: parameter defaults,
// FSM state encodings and the round-robin index helper.
package out_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int DATA_W_DEFAULT  = 32;

  typedef enum logic [7:0] {
    ST_INIT  = 8'd0,
    ST_IDLE  = 8'd1,
    ST_GRANT = 8'd2,
    ST_ACK   = 8'd3
  } arb_state_e;

  // Candidate index 'offset' positions after 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection. The search starts one past
// the previous winner and wraps; the first asserted request wins.
module rr_pick
  import out_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic                       o_any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_winner;
  logic           w_any;

  // Walk candidates farthest-first so the nearest asserted request overwrites
  // all others and ends up as the winner.
  always_comb begin
    w_cand   = '0;
    w_winner = '0;
    w_any    = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IDW'(rr_index(int'(i_last_grant), i, NUM_REQ));
      if (i_req[w_cand]) begin
        w_winner = w_cand;
        w_any    = 1'b1;
      end
    end
  end

  assign o_winner = w_winner;
  assign o_any    = w_any;

endmodule

// File: rtl/out_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared output register, using a four-phase req/ack handshake.
//
// state | meaning
// INIT  | first edge after reset, clears the output register
// IDLE  | waiting for any request; winner latched into grant_id on exit
// GRANT | one cycle; payload of the winner written on exit, ack pulsed
// ACK   | waiting for the winner to drop req before re-arbitrating
module out_arbiter
  import out_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_GRANT_RST = IDW'(NUM_REQ - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDW-1:0]     r_grant_id;
  logic [IDW-1:0]     r_last_grant;
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] w_ack_onehot;
  logic [DATA_W-1:0]  r_out_data;
  logic [DATA_W-1:0]  w_payload;
  logic               r_out_valid;
  logic               w_winner_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  assign w_payload    = req_data[int'(r_grant_id) * DATA_W +: DATA_W];
  assign w_ack_onehot = NUM_REQ'(1) << r_grant_id;
  assign w_winner_req = req[r_grant_id];

  // State register; reset forces INIT so the output clear always runs first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; unknown encodings recover through INIT.
  always_comb begin
    w_state_nxt = ST_INIT;
    case (r_state)
      ST_INIT:  w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = w_any ? ST_GRANT : ST_IDLE;
      ST_GRANT: w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = w_winner_req ? ST_ACK : ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Datapath: winner latch, output write with one-cycle ack/valid pulses,
  // and round-robin pointer update once the winner has released its request.
  // The payload is taken at the GRANT exit edge regardless of req, so a
  // requester withdrawing during GRANT still gets its write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_ack        <= '0;
      r_grant_id   <= '0;
      r_last_grant <= LAST_GRANT_RST;
    end else begin
      r_ack       <= '0;
      r_out_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_out_data <= '0;
        end
        ST_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_winner;
          end
        end
        ST_GRANT: begin
          r_out_data  <= w_payload;
          r_ack       <= w_ack_onehot;
          r_out_valid <= 1'b1;
        end
        ST_ACK: begin
          if (!w_winner_req) begin
            r_last_grant <= r_grant_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_out_arbiter.sv
// Bench for out_arbiter: directed scenarios with literal expectations plus a
// randomized requester population, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_out_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  bit mdl_on   = 1'b0;

  out_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner = requester holding the output (-1 if none); written = its
  // payload has been transferred; init_pending = post-reset clear not done.
  bit           m_init_pending;
  int           m_owner;
  bit           m_written;
  int           m_last;
  int           m_grant;
  int           m_w;
  logic [W-1:0] m_out_data;
  logic [N-1:0] m_ack;
  bit           m_valid;

  function automatic int rr_winner(input int last, input logic [N-1:0] r);
    logic [N-1:0] rot;
    for (int k = 1; k <= N; k++) begin
      rot = r >> ((last + k) % N);
      if (rot[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_init_pending = 1'b1;
      m_owner        = -1;
      m_written      = 1'b0;
      m_last         = N - 1;
      m_grant        = 0;
      m_out_data     = '0;
      m_ack          = '0;
      m_valid        = 1'b0;
    end else begin
      m_ack   = '0;
      m_valid = 1'b0;
      if (m_init_pending) begin
        m_out_data     = '0;
        m_init_pending = 1'b0;
      end else if (m_owner < 0) begin
        m_w = rr_winner(m_last, req);
        if (m_w >= 0) begin
          m_owner   = m_w;
          m_grant   = m_w;
          m_written = 1'b0;
        end
      end else if (!m_written) begin
        m_out_data = req_data[m_owner*W +: W];
        m_ack      = N'(1) << m_owner;
        m_valid    = 1'b1;
        m_written  = 1'b1;
      end else if (((req >> m_owner) & N'(1)) == '0) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("cyc_ack",       64'(ack),       64'(m_ack));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cyc_out_data",  64'(out_data),  64'(m_out_data));
      chk("cyc_grant_id",  64'(grant_id),  64'(m_grant));
      chk("cyc_busy",      64'(busy),      64'(m_init_pending || (m_owner >= 0)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_ack(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget && idx < 0; c++) begin
      step();
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL wait_ack: no ack within %0d cycles at t=%0t", budget, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
  endtask

  int           idx;
  int           n_seen;
  int           order[5];
  int           exp_order[5];
  int           late_acks;
  logic [N-1:0] raise_mask;
  bit           acked[N];
  int           hold[N];

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    exp_order = '{0, 1, 2, 3, 0};
    repeat (3) step();
    mdl_on = 1'b1;

    // reset values
    chk("rst_busy",      64'(busy),      64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_ack",       64'(ack),       64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_grant_id",  64'(grant_id),  64'd0);

    // idle after release
    reset = 1'b1;
    step();
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    repeat (18) step();
    chk("idle20_out_data",  64'(out_data),  64'd0);
    chk("idle20_out_valid", 64'(out_valid), 64'd0);
    chk("idle20_busy",      64'(busy),      64'd0);

    // single requester
    set_data(1, 32'hDEADBEEF);
    req = 4'b0010;
    wait_ack(10, idx);
    chk("single_ack",       64'(ack),       64'h2);
    chk("single_out_data",  64'(out_data),  64'hDEADBEEF);
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_grant_id",  64'(grant_id),  64'd1);
    req = '0;
    step();
    chk("single_ack_pulse", 64'(ack),       64'd0);
    chk("single_valid_pulse", 64'(out_valid), 64'd0);
    repeat (3) step();

    // all four continuously requesting -> fair rotation
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, W'(32'h10 + i));
    req        = 4'hF;
    raise_mask = '0;
    n_seen     = 0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    for (int c = 0; c < 200 && n_seen < 5; c++) begin
      step();
      req        = req | raise_mask;
      raise_mask = '0;
      if (ack != '0) begin
        chk("rr_onehot", 64'($countones(ack)), 64'd1);
        idx = -1;
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        order[n_seen] = idx;
        chk("rr_out_data", 64'(out_data), 64'(32'h10 + idx));
        n_seen++;
        req[idx]        = 1'b0;
        raise_mask[idx] = 1'b1;
      end
    end
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
    req = '0;
    repeat (4) step();

    // winner keeps req high -> stays in ACK
    set_data(2, 32'h12);
    req = 4'b0100;
    wait_ack(10, idx);
    chk("hold_winner", 64'(idx), 64'd2);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_busy",     64'(busy),     64'd1);
      chk("hold_no_ack",   64'(ack),      64'd0);
      chk("hold_out_data", 64'(out_data), 64'h12);
    end
    req = '0;
    step();
    step();
    chk("hold_release_busy", 64'(busy), 64'd0);

    // req drop during GRANT still completes the write
    set_data(3, 32'hCAFE0003);
    req = 4'b1000;
    step();
    chk("drop_in_grant_busy", 64'(busy), 64'd1);
    req = '0;
    step();
    chk("drop_ack",       64'(ack),      64'h8);
    chk("drop_out_data",  64'(out_data), 64'hCAFE0003);
    chk("drop_out_valid", 64'(out_valid), 64'd1);
    late_acks = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ack != '0) late_acks++;
    end
    chk("drop_single_pulse", 64'(late_acks), 64'd0);
    chk("drop_idle_busy",    64'(busy),      64'd0);

    // reset during ACK
    set_data(0, 32'h55);
    req = 4'b0001;
    wait_ack(10, idx);
    chk("rstack_out_data", 64'(out_data), 64'h55);
    reset = 1'b0;
    #1;
    chk("rstack_out_data_cleared", 64'(out_data), 64'd0);
    chk("rstack_ack_cleared",      64'(ack),      64'd0);
    chk("rstack_busy",             64'(busy),     64'd1);
    req = '0;
    step();
    reset = 1'b1;
    step();
    set_data(0, 32'hA0);
    set_data(3, 32'hA3);
    req = 4'b1001;
    wait_ack(10, idx);
    chk("rstack_first_winner", 64'(idx),      64'd0);
    chk("rstack_first_data",   64'(out_data), 64'hA0);
    req = '0;
    repeat (3) step();

    // randomized requester population
    for (int i = 0; i < N; i++) begin
      acked[i] = 1'b0;
      hold[i]  = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 700 == 350) begin
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) acked[i] = 1'b0;
        step();
        step();
        reset = 1'b1;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i] && req[i]) begin
          acked[i] = 1'b1;
          hold[i]  = int'($urandom_range(0, 3));
        end
        if (req[i]) begin
          if (acked[i]) begin
            if (hold[i] == 0) begin
              req[i]   = 1'b0;
              acked[i] = 1'b0;
            end else begin
              hold[i]--;
            end
          end else if ($urandom_range(0, 49) == 0) begin
            req[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            set_data(i, W'($urandom()));
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i]   = 1'b1;
          acked[i] = 1'b0;
          set_data(i, W'($urandom()));
        end
      end
    end
    req = '0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
